// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: FSM states and default parameters.
package change_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int DEF_NUM_DENOM = 4;
  localparam int DEF_AMT_W     = 10;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_INV_W     = 8;
  localparam int DEF_INV_RESET = 10;

  // Entry 0 is the largest coin; packed concatenation lists the highest index first.
  localparam logic [DEF_NUM_DENOM-1:0][DEF_AMT_W-1:0] DEF_DENOMS =
    {10'd1, 10'd5, 10'd10, 10'd25};

  // Index width that stays legal for a single-denomination build.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational picker: lowest-index denomination that may legally be paid next.
module coin_select
  import change_pkg::*;
#(
  parameter int NUM_DENOM = DEF_NUM_DENOM,
  parameter int AMT_W     = DEF_AMT_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int INV_W     = DEF_INV_W,
  parameter logic [NUM_DENOM-1:0][AMT_W-1:0] DENOMS = DEF_DENOMS,
  localparam int SEL_W    = sel_width(NUM_DENOM)
) (
  input  logic [AMT_W-1:0]                  remaining,
  input  logic [NUM_DENOM-1:0][INV_W-1:0]   inventory,
  input  logic [NUM_DENOM-1:0][CNT_W-1:0]   counts,
  output logic                              found,
  output logic [SEL_W-1:0]                  idx
);

  logic [NUM_DENOM-1:0] elig;

  // A coin fits the balance, is in stock, and its counter has headroom.
  for (genvar i = 0; i < NUM_DENOM; i++) begin : g_elig
    assign elig[i] = (DENOMS[i] <= remaining) &&
                     (inventory[i] != '0) &&
                     (counts[i] != '1);
  end

  // Priority encode toward index 0 (largest coin wins).
  always_comb begin
    found = |elig;
    idx   = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (elig[i]) idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: one coin per cycle, bounded by inventory and count width.
module change_dispenser
  import change_pkg::*;
#(
  parameter int NUM_DENOM = DEF_NUM_DENOM,
  parameter int AMT_W     = DEF_AMT_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int INV_W     = DEF_INV_W,
  parameter logic [NUM_DENOM-1:0][AMT_W-1:0] DENOMS = DEF_DENOMS,
  parameter int INV_RESET = DEF_INV_RESET,
  localparam int SEL_W    = sel_width(NUM_DENOM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AMT_W-1:0]           amount,
  input  logic                       inv_load,
  input  logic [SEL_W-1:0]           inv_sel,
  input  logic [INV_W-1:0]           inv_value,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       coin_valid,
  output logic [SEL_W-1:0]           coin_idx,
  output logic [NUM_DENOM*CNT_W-1:0] counts,
  output logic [AMT_W-1:0]           remaining
);

  state_t state, next_state;

  logic [NUM_DENOM-1:0][INV_W-1:0] inventory;
  logic [NUM_DENOM-1:0][CNT_W-1:0] counts_q;
  logic [AMT_W-1:0]                remaining_q;
  logic                            error_q;
  logic                            done_q;

  logic             found;
  logic [SEL_W-1:0] sel_idx;
  logic             load_txn, take_coin, set_err;

  coin_select #(
    .NUM_DENOM (NUM_DENOM),
    .AMT_W     (AMT_W),
    .CNT_W     (CNT_W),
    .INV_W     (INV_W),
    .DENOMS    (DENOMS)
  ) u_sel (
    .remaining (remaining_q),
    .inventory (inventory),
    .counts    (counts_q),
    .found     (found),
    .idx       (sel_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    load_txn   = 1'b0;
    take_coin  = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_txn   = 1'b1;
          next_state = DISPENSE;
        end
      end
      DISPENSE: begin
        if (remaining_q == '0) begin
          next_state = DONE;
        end else if (found) begin
          take_coin = 1'b1;
        end else begin
          set_err    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        // DONE spans two cycles; leave once the registered done pulse is out.
        if (done_q) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Transaction datapath, inventory and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DENOM; i++) inventory[i] <= INV_W'(INV_RESET);
      counts_q    <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == DONE) && !done_q;
      // Inventory writes land before DISPENSE looks at stock, even with start.
      if (state == IDLE && inv_load) begin
        for (int i = 0; i < NUM_DENOM; i++) begin
          if (inv_sel == SEL_W'(i)) inventory[i] <= inv_value;
        end
      end
      if (load_txn) begin
        remaining_q <= amount;
        counts_q    <= '0;
        error_q     <= 1'b0;
      end
      if (take_coin) begin
        for (int i = 0; i < NUM_DENOM; i++) begin
          if (sel_idx == SEL_W'(i)) begin
            remaining_q  <= remaining_q - DENOMS[i];
            inventory[i] <= inventory[i] - INV_W'(1);
            counts_q[i]  <= counts_q[i] + CNT_W'(1);
          end
        end
      end
      if (set_err) error_q <= 1'b1;
    end
  end

  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign coin_valid = take_coin;
  assign coin_idx   = take_coin ? sel_idx : '0;
  assign counts     = counts_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser with a block-greedy reference model.
module tb_change_dispenser;

  localparam int ND = 4;
  localparam int AW = 10;
  localparam int CW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] amount;
  logic          inv_load;
  logic [1:0]    inv_sel;
  logic [IW-1:0] inv_value;
  logic          busy, done, error, coin_valid;
  logic [1:0]    coin_idx;
  logic [ND*CW-1:0] counts;
  logic [AW-1:0] remaining;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .inv_load(inv_load), .inv_sel(inv_sel), .inv_value(inv_value),
    .busy(busy), .done(done), .error(error), .coin_valid(coin_valid),
    .coin_idx(coin_idx), .counts(counts), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          err;
    int          rem;
    logic [15:0] cnts;
    int          dcyc;
  } res_t;

  int   den[ND] = '{25, 10, 5, 1};
  int   m_inv[ND];
  int   cq[$];
  res_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   coins_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-transaction model: each denomination is paid as one block, the
  // largest number allowed by balance, stock and the 15-coin counter limit.
  task automatic model_run(input int amt, input int coin_lim, output int k, output res_t r);
    int rem;
    rem = amt;
    k = 0;
    r.cnts = '0;
    for (int i = 0; i < ND; i++) begin
      int n;
      n = rem / den[i];
      if (n > m_inv[i]) n = m_inv[i];
      if (n > 15) n = 15;
      rem -= n * den[i];
      m_inv[i] -= n;
      r.cnts[i*4 +: 4] = 4'(n);
      for (int j = 0; j < n; j++) begin
        if (k < coin_lim) cq.push_back(i);
        k++;
      end
    end
    r.err  = (rem != 0) ? 1 : 0;
    r.rem  = rem;
    r.dcyc = 0;
  endtask

  // Monitor: pop and compare whenever the DUT presents a coin or a done.
  always @(negedge clk) begin
    if (!reset) begin
      if (coin_valid) begin
        coins_seen++;
        if (cq.size() == 0) chk("unexpected_coin", 1, 0);
        else chk("coin_idx", int'(coin_idx), cq.pop_front());
      end
      if (done) begin
        if (rq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          res_t r;
          r = rq.pop_front();
          chk("error", int'(error), r.err);
          chk("remaining", int'(remaining), r.rem);
          chk("counts", int'(counts), int'(r.cnts));
          chk("done_cycle", cyc, r.dcyc);
          chk("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  task automatic load_inv(input int sel, input int val);
    @(negedge clk);
    inv_load  = 1'b1;
    inv_sel   = 2'(sel);
    inv_value = 8'(val);
    @(negedge clk);
    inv_load  = 1'b0;
    m_inv[sel] = val;
  endtask

  task automatic run_txn(input int amt, input bit disturb);
    int   k;
    res_t r;
    bit   got;
    model_run(amt, 1000, k, r);
    @(negedge clk);
    start  = 1'b1;
    amount = AW'(amt);
    @(posedge clk);
    #1;
    r.dcyc = cyc + k + 2;
    rq.push_back(r);
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (disturb) begin
        start     = 1'b1;
        amount    = AW'($urandom_range(0, 1023));
        inv_load  = 1'b1;
        inv_sel   = 2'($urandom_range(0, 3));
        inv_value = 8'($urandom_range(0, 255));
      end else start = 1'b0;
    end
    start    = 1'b0;
    inv_load = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_coin_valid"}, int'(coin_valid), 0);
    chk({tag, "_coin_idx"}, int'(coin_idx), 0);
    chk({tag, "_counts"}, int'(counts), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  task automatic abort_txn(input int amt);
    int   k;
    res_t r;
    int   base;
    bit   hit;
    base = coins_seen;
    model_run(amt, 3, k, r);
    @(negedge clk);
    start  = 1'b1;
    amount = AW'(amt);
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      if (coins_seen >= base + 3) hit = 1'b1;
      else begin
        @(negedge clk);
        #2;
      end
    end
    if (!hit) chk("abort_coin_timeout", 0, 1);
    reset = 1'b1;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < ND; i++) m_inv[i] = 10;
    cq.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; amount = '0;
    inv_load = 1'b0; inv_sel = '0; inv_value = '0;
    for (int i = 0; i < ND; i++) m_inv[i] = 10;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    run_txn(67, 1'b0);
    run_txn(0, 1'b0);
    load_inv(0, 1);
    run_txn(60, 1'b0);
    load_inv(0, 0); load_inv(1, 0); load_inv(2, 0); load_inv(3, 3);
    run_txn(7, 1'b0);

    for (int i = 0; i < ND; i++) load_inv(i, 10);
    run_txn(67, 1'b1);

    for (int i = 0; i < ND; i++) load_inv(i, 10);
    abort_txn(67);
    // A fresh stock of ten quarters pays 250 entirely in quarters.
    run_txn(250, 1'b0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) load_inv($urandom_range(0, 3), $urandom_range(0, 12));
      run_txn($urandom_range(0, 300), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("coin_queue_empty", cq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter NUM_DENOM, default 4: number of coin denominations.
REQ-002 Parameter AMT_W, default 10: amount width in cents.
REQ-003 Parameter CNT_W, default 4: width of each per-denomination output count.
REQ-004 Parameter INV_W, default 8: width of each per-denomination inventory counter.
REQ-005 Parameter DENOMS, default {25,10,5,1}: denomination values, strictly descending, entry 0 the largest.
REQ-006 Parameter INV_RESET, default 10: inventory value of every denomination after reset.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request to dispense; sampled only in IDLE.
REQ-010 amount  input  AMT_W  change to dispense, captured with start.
REQ-011 inv_load  input  1  inventory write strobe; honoured only in IDLE.
REQ-012 inv_sel  input  clog2(NUM_DENOM)  inventory entry selected by inv_load.
REQ-013 inv_value  input  INV_W  value written to the selected inventory entry.
REQ-014 busy  output  1  high in DISPENSE and DONE.
REQ-015 done  output  1  one-cycle pulse marking the end of a transaction.
REQ-016 error  output  1  valid with done; 1 = amount not fully paid.
REQ-017 coin_valid  output  1  one-cycle pulse per coin dispensed.
REQ-018 coin_idx  output  clog2(NUM_DENOM)  denomination index of the current coin.
REQ-019 counts  output  NUM_DENOM*CNT_W  packed per-denomination coin counts for the current or last transaction.
REQ-020 remaining  output  AMT_W  amount still unpaid.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, DISPENSE and DONE.
REQ-022 IDLE with start=1: latch amount into remaining, clear counts and error, go to DISPENSE.
REQ-023 DISPENSE with remaining=0: go to DONE and issue no coin.
REQ-024 In DISPENSE, denomination i is eligible when all of the following hold:
- DENOMS[i] <= remaining;
- inventory[i] > 0;
- counts[i] < 2^CNT_W-1.
REQ-025 DISPENSE with at least one eligible denomination: select the lowest eligible i, then in that same cycle:
- pulse coin_valid with coin_idx=i;
- subtract DENOMS[i] from remaining;
- decrement inventory[i];
- increment counts[i].
REQ-026 DISPENSE with remaining>0 and no eligible denomination: set error=1 and go to DONE; remaining holds the unpaid value.
REQ-027 DONE: done=1 for exactly one cycle, then go to IDLE; counts, error and remaining hold until the next start.
REQ-028 Latency: a transaction of k coins asserts done in the cycle following the (k+2)th rising edge after the edge that sampled start.
REQ-029 start, amount and inv_load SHALL be ignored while busy=1.
REQ-030 inv_load and start in the same IDLE cycle: the inventory write completes before the first DISPENSE eligibility check.
REQ-031 All arithmetic SHALL be unsigned and never wrap; the eligibility rules guarantee remaining, inventory and counts cannot underflow or overflow.

Reset
REQ-032 reset SHALL act asynchronously and force:
- state to IDLE;
- every inventory entry to INV_RESET;
- counts, remaining, busy, done, error, coin_valid and coin_idx to 0.
REQ-033 reset asserted mid-transaction SHALL abort it with no done pulse, leaving inventory at INV_RESET.

Structure
REQ-034 Shared package change_pkg SHALL hold the state enum, the default DENOMS array and the default parameter constants.
REQ-035 Sub-module coin_select SHALL be purely combinational: inputs remaining, inventory and counts; outputs found and idx (lowest eligible index).

Verification
REQ-036 Reset, amount=67, start -> coins 0,0,1,2,3,3 in order; counts={2,1,1,2}; done in the 8th cycle after start; error=0; quarter inventory 8.
REQ-037 amount=0, start -> no coin_valid; done after 2 edges; error=0; counts all 0.
REQ-038 Load quarter inventory=1, amount=60 -> coins 0,1,1,1,2; error=0; quarter inventory 0.
REQ-039 Load all inventories=0 except pennies=3, amount=7 -> 3 penny coins; done with error=1; remaining=4.
REQ-040 Assert start and inv_load during DISPENSE -> both ignored; result identical to the undisturbed run.
REQ-041 Assert reset on the 3rd coin of amount=67 -> outputs 0 immediately; no done; all inventories 10.
